pipe_dmem_resp: RTL

Data-memory responder for the five-stage pipeline's MEM-stage bus. It accepts the stage's load and store requests. Stores are posted into a 4-entry store buffer that drains into a single-port word array whenever the port is idle. Loads return data in the same cycle, forwarded from the youngest matching buffered store when one exists. The block sits between the EM pipeline register outputs (`mwmem`, `malu`, `mb`) and the MW register input (`mmo`). Its stall output feeds the pipeline's hazard/stall logic.

---
 rtl/pipe_dmem_resp.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_dmem_resp.sv
// pipe_dmem_resp: MEM-stage data memory responder.
// Stores post into a small circular store buffer that drains into a
// single-port word array on cycles without a load. Loads are answered
// combinationally. The youngest matching buffered store wins over the array.
module pipe_dmem_resp #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mwmem,
    input  logic                        mrd,
    input  logic [31:0]                 malu,
    input  logic [31:0]                 mb,
    output logic [31:0]                 mmo,
    output logic                        mstall,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_empty
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WORDS = 1 << ADDR_W;

    // Store buffer: control state is reset, payload is not
    logic [ADDR_W-1:0]  r_sb_idx   [SB_DEPTH];
    logic [31:0]        r_sb_data  [SB_DEPTH];
    logic [SB_DEPTH-1:0] r_sb_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    // Backing word array, deliberately left uninitialised by reset
    logic [31:0]        r_mem [WORDS];

    logic [ADDR_W-1:0]  w_idx;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_drain;
    logic               w_hit;
    logic [31:0]        w_fwd_data;
    logic [PTR_W-1:0]   w_slot;
    logic               w_unused_malu;

    assign w_idx         = malu[ADDR_W+1:2];
    assign w_unused_malu = ^{malu[31:ADDR_W+2], malu[1:0]};

    // Fullness/emptiness come from the start-of-cycle count only
    assign w_full  = (r_count == CNT_W'(SB_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = mwmem & ~w_full;
    assign w_drain = ~mrd & ~w_empty;

    assign mstall   = mwmem & w_full;
    assign sb_count = r_count;
    assign sb_empty = w_empty;

    // Buffer pointers, occupancy and valid bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_sb_valid <= '0;
        end else begin
            if (w_push) begin
                r_tail             <= r_tail + PTR_W'(1);
                r_sb_valid[r_tail] <= 1'b1;
            end
            if (w_drain) begin
                r_head             <= r_head + PTR_W'(1);
                r_sb_valid[r_head] <= 1'b0;
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer payload written at the tail on an accepted store
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_sb_idx[r_tail]  <= w_idx;
            r_sb_data[r_tail] <= mb;
        end
    end

    // Head entry retires into the array; reset empties the buffer first,
    // so a drain cannot fire on an edge while reset is asserted
    always_ff @(posedge clock) begin
        if (w_drain) begin
            r_mem[r_sb_idx[r_head]] <= r_sb_data[r_head];
        end
    end

    // Forwarding search from oldest to youngest, so the last match wins
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_slot     = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_slot = r_head + PTR_W'(k);
            if (r_sb_valid[w_slot] && (r_sb_idx[w_slot] == w_idx)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_sb_data[w_slot];
            end
        end
    end

    // Load data: forwarded, array, or zero when no load is requested
    always_comb begin
        mmo = '0;
        if (mrd) begin
            mmo = w_hit ? w_fwd_data : r_mem[w_idx];
        end
    end

endmodule
